// File: rtl/cam_reg_init_seq_pkg.sv
// Shared definitions for the camera register init sequencer and its ROM.
`timescale 1ns/1ps
package cam_cfg_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_WAIT_READY = 4'd1,
        S_FETCH      = 4'd2,
        S_STORE_ADDR = 4'd3,
        S_STORE_VAL  = 4'd4,
        S_GAP        = 4'd5,
        S_SEND       = 4'd6,
        S_WAIT_DONE  = 4'd7,
        S_DELAY      = 4'd8,
        S_DONE       = 4'd9,
        S_ERROR      = 4'd10
    } t_cfg_state;

    localparam logic [15:0] ROM_END_MARKER   = 16'hFFFF;
    localparam logic [7:0]  ROM_DELAY_PREFIX = 8'hFE;
    localparam logic [7:0]  COM7_ADDR        = 8'h12;
    localparam logic [7:0]  COM7_SOFT_RESET  = 8'h80;

endpackage

// File: rtl/cam_reg_rom.sv
// OV7670 register init table: {reg_addr, reg_value} entries, one-cycle synchronous read.
`timescale 1ns/1ps
module cam_reg_rom
    import cam_cfg_pkg::*;
#(
    parameter int  ROM_DEPTH = 128,
    localparam int AW        = $clog2(ROM_DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [15:0]   data
);

    function automatic logic [15:0] entry(input logic [AW-1:0] a);
        case (int'(a))
            0:       entry = {COM7_ADDR, COM7_SOFT_RESET};
            1:       entry = {ROM_DELAY_PREFIX, 8'h0A};   // 10 ms settle after soft reset
            2:       entry = 16'h1204;                    // COM7: RGB output
            3:       entry = 16'h1100;                    // CLKRC: no prescale
            4:       entry = 16'h0C00;                    // COM3
            5:       entry = 16'h3E00;                    // COM14
            6:       entry = 16'h8C00;                    // RGB444 off
            7:       entry = 16'h0400;                    // COM1
            8:       entry = 16'h4010;                    // COM15: RGB565
            9:       entry = 16'h3A04;                    // TSLB
            10:      entry = 16'h1438;                    // COM9: AGC ceiling
            11:      entry = 16'h4FB3;                    // MTX1..MTX6, MTXS
            12:      entry = 16'h50B3;
            13:      entry = 16'h5100;
            14:      entry = 16'h523D;
            15:      entry = 16'h53A7;
            16:      entry = 16'h54E4;
            17:      entry = 16'h589E;
            18:      entry = 16'h3DC0;                    // COM13: gamma, UV auto
            19:      entry = 16'h1711;                    // HSTART/HSTOP/HREF
            20:      entry = 16'h1861;
            21:      entry = 16'h32A4;
            22:      entry = 16'h1903;                    // VSTART/VSTOP/VREF
            23:      entry = 16'h1A7B;
            24:      entry = 16'h030A;
            default: entry = ROM_END_MARKER;
        endcase
    endfunction

    // NOTE: a ROM output register needs no reset; the reader waits a cycle before using it.
    always_ff @(posedge clk) begin
        data <= entry(addr);
    end

endmodule

// File: rtl/cam_reg_init_seq.sv
// Walks the register ROM and pushes each {addr, value} pair through the shared I2C command FSM.
// Optional: define CAM_CFG_SOFT_RESET_EN to write COM7=0x80 and wait one delay unit before the walk.
`timescale 1ns/1ps
module cam_reg_init_seq
    import cam_cfg_pkg::*;
#(
    parameter int  MAIN_CLOCK_FREQUENCY = 27_000_000,
    parameter int  ROM_DEPTH            = 128,
    parameter int  DELAY_UNIT_CYCLES    = 27_000,
    parameter int  DONE_TIMEOUT_CYCLES  = 2_700_000,
    parameter bit  AUTO_START           = 1'b1,
    localparam int AW                   = $clog2(ROM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          i2c_ready,
    input  logic          i2c_done,
    output logic          store_data,
    output logic          send_data,
    output logic [7:0]    data_out,
    output logic [AW-1:0] rom_addr,
    input  logic [15:0]   rom_data,
    output logic          cfg_busy,
    output logic          cfg_done,
    output logic          cfg_error
);

    localparam int TO_W  = $clog2(DONE_TIMEOUT_CYCLES);
    localparam int DLY_W = $clog2(255 * DELAY_UNIT_CYCLES);

    if (DELAY_UNIT_CYCLES < 1 || DELAY_UNIT_CYCLES > MAIN_CLOCK_FREQUENCY) begin : g_bad_delay_unit
        $error("DELAY_UNIT_CYCLES must lie between 1 and MAIN_CLOCK_FREQUENCY");
    end

    t_cfg_state       state;
    logic             first_pass;
    logic             fetch_wait;
    logic             soft_phase;
    logic [TO_W-1:0]  to_cnt;
    logic [DLY_W-1:0] dly_cnt;

    // Advancing past the last entry ends the run without wrapping the address.
    logic             last_entry;
    t_cfg_state       adv_state;
    logic [AW-1:0]    adv_addr;

    assign last_entry = (rom_addr == AW'(ROM_DEPTH - 1));
    assign adv_state  = last_entry ? S_DONE : S_FETCH;
    assign adv_addr   = last_entry ? rom_addr : rom_addr + AW'(1);

    // NOTE: all state here is written with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rom_addr   <= '0;
            first_pass <= 1'b1;
            fetch_wait <= 1'b0;
            soft_phase <= 1'b0;
            to_cnt     <= '0;
            dly_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start || (state == S_IDLE && AUTO_START && first_pass)) begin
                        state      <= S_WAIT_READY;
                        first_pass <= 1'b0;
                    end
                end
                S_WAIT_READY: begin
                    if (i2c_ready) begin
                        rom_addr   <= '0;
                        fetch_wait <= 1'b0;
`ifdef CAM_CFG_SOFT_RESET_EN
                        soft_phase <= 1'b1;
                        state      <= S_STORE_ADDR;
`else
                        state      <= S_FETCH;
`endif
                    end
                end
                S_FETCH: begin
                    if (!fetch_wait) begin
                        fetch_wait <= 1'b1;
                    end else begin
                        fetch_wait <= 1'b0;
                        if (rom_data == ROM_END_MARKER) begin
                            state <= S_DONE;
                        end else if (rom_data[15:8] == ROM_DELAY_PREFIX) begin
                            if (rom_data[7:0] == 8'h00) begin
                                state    <= adv_state;
                                rom_addr <= adv_addr;
                            end else begin
                                // Loaded with N-1 so DELAY lasts exactly N cycles.
                                dly_cnt <= DLY_W'(rom_data[7:0]) * DLY_W'(DELAY_UNIT_CYCLES) - DLY_W'(1);
                                state   <= S_DELAY;
                            end
                        end else begin
                            state <= S_STORE_ADDR;
                        end
                    end
                end
                S_STORE_ADDR: state <= S_STORE_VAL;
                S_STORE_VAL:  state <= S_GAP;
                S_GAP:        state <= S_SEND;
                S_SEND: begin
                    to_cnt <= '0;
                    state  <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (i2c_done) begin
                        if (soft_phase) begin
                            dly_cnt <= DLY_W'(DELAY_UNIT_CYCLES - 1);
                            state   <= S_DELAY;
                        end else begin
                            state    <= adv_state;
                            rom_addr <= adv_addr;
                        end
                    end else if (to_cnt == TO_W'(DONE_TIMEOUT_CYCLES - 1)) begin
                        state <= S_ERROR;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_DELAY: begin
                    if (dly_cnt != '0) begin
                        dly_cnt <= dly_cnt - DLY_W'(1);
                    end else if (soft_phase) begin
                        soft_phase <= 1'b0;
                        state      <= S_FETCH;
                    end else begin
                        state    <= adv_state;
                        rom_addr <= adv_addr;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign store_data = (state == S_STORE_ADDR) || (state == S_STORE_VAL);
    assign send_data  = (state == S_SEND);
    assign cfg_busy   = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign cfg_done   = (state == S_DONE);
    assign cfg_error  = (state == S_ERROR);

    // NOTE: the default assignment first keeps this always_comb free of inferred latches.
    always_comb begin
        data_out = 8'h00;
        if (state == S_STORE_ADDR) begin
            data_out = soft_phase ? COM7_ADDR : rom_data[15:8];
        end else if (state == S_STORE_VAL) begin
            data_out = soft_phase ? COM7_SOFT_RESET : rom_data[7:0];
        end
    end

endmodule

// File: tb/tb_cam_reg_init_seq.sv
// Directed bench for cam_reg_init_seq: bench-side ROM model and I2C responder, immediate-assert checks.
`timescale 1ns/1ps
module tb_cam_reg_init_seq;

    localparam int DEPTH    = 4;
    localparam int UNIT     = 10;
    localparam int TIMEOUT  = 200;
    localparam int DONE_LAT = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        i2c_ready = 1'b0;
    logic        i2c_done = 1'b0;
    logic        store_data, send_data;
    logic [7:0]  data_out;
    logic [1:0]  rom_addr;
    logic [15:0] rom_data;
    logic        cfg_busy, cfg_done, cfg_error;

    logic [15:0] rom_mem [DEPTH];
    logic [6:0]  chk_addr = 7'd0;
    logic [15:0] chk_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int no_ack_idx = -1;

    logic [7:0] stores [$];
    int         store_cyc [$];
    int         sends = 0;
    int         last_send_cyc = 0;
    int         gap_bad = 0;
    int         run_bad = 0;
    int         early = 0;
    int         run = 0;
    logic [1:0] hist = 2'b00;

    cam_reg_init_seq #(
        .ROM_DEPTH          (DEPTH),
        .DELAY_UNIT_CYCLES  (UNIT),
        .DONE_TIMEOUT_CYCLES(TIMEOUT),
        .AUTO_START         (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .i2c_ready (i2c_ready),
        .i2c_done  (i2c_done),
        .store_data(store_data),
        .send_data (send_data),
        .data_out  (data_out),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error)
    );

    cam_reg_rom #(.ROM_DEPTH(128)) u_rom (
        .clk (clk),
        .addr(chk_addr),
        .data(chk_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // Answers each send DONE_LAT cycles later, except for the entry index chosen to hang.
    initial begin : responder
        forever begin
            @(negedge clk);
            if (send_data && (int'(rom_addr) != no_ack_idx)) begin
                repeat (DONE_LAT - 1) @(negedge clk);
                i2c_done = 1'b1;
                @(negedge clk);
                i2c_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        if (store_data) begin
            stores.push_back(data_out);
            store_cyc.push_back(cyc);
        end
        if (send_data) begin
            sends++;
            last_send_cyc = cyc;
            if (!(hist[0] == 1'b0 && hist[1] == 1'b1)) gap_bad++;
        end
        if (store_data) begin
            run++;
        end else begin
            if (run != 0 && run != 2) run_bad++;
            run = 0;
        end
        hist[1] = hist[0];
        hist[0] = store_data;
        if (!i2c_ready && (store_data || send_data)) early++;
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_store_data"}, 32'(store_data), 32'd0);
        check({pfx, "_send_data"},  32'(send_data),  32'd0);
        check({pfx, "_data_out"},   32'(data_out),   32'd0);
        check({pfx, "_rom_addr"},   32'(rom_addr),   32'd0);
        check({pfx, "_cfg_busy"},   32'(cfg_busy),   32'd0);
        check({pfx, "_cfg_done"},   32'(cfg_done),   32'd0);
        check({pfx, "_cfg_error"},  32'(cfg_error),  32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cfg_done || cfg_error) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    initial begin : main
        int base_st, base_sd, base_gap, base_run, c0, d;
        bit hit;

        rom_mem = '{16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF};
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");

        chk_addr = 7'd0;
        @(negedge clk);
        check("rom_entry0", 32'(chk_data), 32'h1280);
        chk_addr = 7'd1;
        @(negedge clk);
        check("rom_entry1", 32'(chk_data), 32'hFE0A);

        // Auto-start with i2c_ready withheld for 100 cycles.
        base_st = stores.size(); base_sd = sends; base_gap = gap_bad; base_run = run_bad;
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("ready_low_busy", 32'(cfg_busy), 32'd1);
        check("ready_low_stores", 32'(stores.size() - base_st), 32'd0);
        check("ready_low_sends", 32'(sends - base_sd), 32'd0);
        i2c_ready = 1'b1;
        wait_end(2000, hit);
        check("t1_finished", 32'(hit), 32'd1);
        check("t1_store_count", 32'(stores.size() - base_st), 32'd4);
        check("t1_byte0", 32'(stores[base_st]),     32'h12);
        check("t1_byte1", 32'(stores[base_st + 1]), 32'h80);
        check("t1_byte2", 32'(stores[base_st + 2]), 32'h11);
        check("t1_byte3", 32'(stores[base_st + 3]), 32'h01);
        check("t1_send_count", 32'(sends - base_sd), 32'd2);
        check("t1_gap_before_send", 32'(gap_bad - base_gap), 32'd0);
        check("t1_store_pairs", 32'(run_bad - base_run), 32'd0);
        check("t1_no_early_activity", 32'(early), 32'd0);
        check("t1_cfg_done", 32'(cfg_done), 32'd1);
        check("t1_cfg_busy", 32'(cfg_busy), 32'd0);
        check("t1_cfg_error", 32'(cfg_error), 32'd0);
        check("t1_rom_addr", 32'(rom_addr), 32'd2);

        // FE03 delay entry: decode lands 4 edges after start is driven, delay is 3*UNIT cycles.
        rom_mem = '{16'hFE03, 16'h1502, 16'hFFFF, 16'hFFFF};
        base_st = stores.size(); base_sd = sends;
        c0 = cyc;
        pulse_start();
        wait_end(2000, hit);
        check("t2_finished", 32'(hit), 32'd1);
        check("t2_store_count", 32'(stores.size() - base_st), 32'd2);
        d = store_cyc[base_st] - (c0 + 4);
        check("t2_delay_in_window", 32'((d >= 28) && (d <= 32)), 32'd1);
        check("t2_byte0", 32'(stores[base_st]),     32'h15);
        check("t2_byte1", 32'(stores[base_st + 1]), 32'h02);
        check("t2_cfg_done", 32'(cfg_done), 32'd1);

        // Entry 1 never acknowledged: error appears 200 cycles after the send pulse ends.
        rom_mem = '{16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF};
        no_ack_idx = 1;
        base_sd = sends;
        pulse_start();
        wait_end(3000, hit);
        check("t3_finished", 32'(hit), 32'd1);
        check("t3_cfg_error", 32'(cfg_error), 32'd1);
        check("t3_cfg_done", 32'(cfg_done), 32'd0);
        check("t3_cfg_busy", 32'(cfg_busy), 32'd0);
        check("t3_fail_index", 32'(rom_addr), 32'd1);
        check("t3_send_count", 32'(sends - base_sd), 32'd2);
        check("t3_timeout_cycles", 32'(cyc - last_send_cyc), 32'd201);

        no_ack_idx = -1;
        base_st = stores.size();
        pulse_start();
        check("t3_restart_clears_error", 32'(cfg_error), 32'd0);
        check("t3_restart_busy", 32'(cfg_busy), 32'd1);
        wait_end(2000, hit);
        check("t3_rerun_finished", 32'(hit), 32'd1);
        check("t3_rerun_store_count", 32'(stores.size() - base_st), 32'd4);
        check("t3_rerun_byte0", 32'(stores[base_st]), 32'h12);
        check("t3_rerun_cfg_done", 32'(cfg_done), 32'd1);

        // No end marker: all four entries written, then implicit end at the last index.
        rom_mem = '{16'h1201, 16'h1302, 16'h1403, 16'h1504};
        base_st = stores.size(); base_sd = sends;
        pulse_start();
        repeat (10) @(negedge clk);
        check("t4_busy_mid_run", 32'(cfg_busy), 32'd1);
        pulse_start();
        wait_end(3000, hit);
        check("t4_finished", 32'(hit), 32'd1);
        check("t4_store_count", 32'(stores.size() - base_st), 32'd8);
        check("t4_send_count", 32'(sends - base_sd), 32'd4);
        check("t4_first_byte", 32'(stores[base_st]), 32'h12);
        check("t4_last_byte", 32'(stores[base_st + 7]), 32'h04);
        check("t4_rom_addr", 32'(rom_addr), 32'd3);
        check("t4_cfg_done", 32'(cfg_done), 32'd1);

        // Reset while waiting on entry 1, then auto-start reruns the table.
        rom_mem = '{16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF};
        no_ack_idx = 1;
        base_sd = sends;
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (sends - base_sd >= 2) begin
                hit = 1'b1;
                break;
            end
        end
        check("t5_reached_second_send", 32'(hit), 32'd1);
        repeat (5) @(negedge clk);
        check("t5_busy_in_wait_done", 32'(cfg_busy), 32'd1);
        check("t5_addr_in_wait_done", 32'(rom_addr), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("t5_mid_reset");
        no_ack_idx = -1;
        base_st = stores.size();
        rst = 1'b0;
        wait_end(2000, hit);
        check("t5_restart_finished", 32'(hit), 32'd1);
        check("t5_restart_cfg_done", 32'(cfg_done), 32'd1);
        check("t5_restart_cfg_error", 32'(cfg_error), 32'd0);
        check("t5_restart_store_count", 32'(stores.size() - base_st), 32'd4);
        check("t5_restart_byte0", 32'(stores[base_st]), 32'h12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
